// File: rtl/fft_window_input_buffer.sv
// fft_window_input_buffer
// Ping-pong framing buffer between the audio sample stream and the FFT core.
// Samples arriving on the audio_input valid/ready stream are packed into
// windows of NSamples words, alternating between two RAM banks. Each complete
// window is replayed as one uninterrupted burst of NSamples words, oldest
// first, with at least one idle cycle between bursts.
//
// The audio_input stream is carried as three flat ports:
// audio_input_data / audio_input_valid / audio_input_ready.
//
// Optional feature macro: FFT_INPUT_BUFFER_START_PULSE_EN
//   defined   -> adds output fft_input_start, a one-cycle pulse on the first
//                valid sample (index 0) of each burst.
//   undefined -> the port and its logic are absent.
//
// reset is asynchronous and active-low. RAM contents are never reset.
module fft_window_input_buffer #(
  parameter int W        = 16,
  parameter int NSamples = 1024  // power of two, >= 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] audio_input_data,
  input  logic         audio_input_valid,
  output logic         audio_input_ready,
  output logic [W-1:0] fft_input,
  output logic         fft_input_valid
`ifdef FFT_INPUT_BUFFER_START_PULSE_EN
  ,
  output logic         fft_input_start
`endif
);

  localparam int            AW        = $clog2(NSamples);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NSamples - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    GAP
  } rd_state_t;

  // Both banks live in one array; the bank number is the top address bit.
  logic [W-1:0]  ram [2*NSamples];

  logic [AW-1:0] wr_addr;
  logic          wr_bank;
  logic [AW-1:0] rd_addr;
  // Next bank to replay. Banks fill strictly 0,1,0,1,... so reading them in
  // the same order keeps windows in arrival order.
  logic          rd_bank;
  logic [1:0]    full;
  rd_state_t     rd_state;

  logic          accept;
  logic          wr_last;
  logic          rd_en;
  logic          rd_last;

  // The producer stalls only while the bank it would write next still holds
  // a window that has not been completely replayed.
  assign audio_input_ready = ~full[wr_bank];
  assign accept            = audio_input_valid & audio_input_ready;
  assign wr_last           = accept & (wr_addr == LAST_ADDR);
  assign rd_en             = (rd_state == READ);
  assign rd_last           = rd_en & (rd_addr == LAST_ADDR);

  // Write pointer: advance on every accepted sample, switch bank on the last
  // word of a window (the address wraps naturally since NSamples is 2^AW).
  // NOTE: every register of sequential state is updated with <= so all flops
  // sample the pre-edge values regardless of block or statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_addr <= '0;
      wr_bank <= 1'b0;
    end else if (accept) begin
      wr_addr <= wr_addr + 1'b1;
      if (wr_last) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Bank full flags: set when the writer completes a bank, cleared once the
  // reader has issued the last address of it. Both may happen in one cycle on
  // different banks; the writer can never complete the bank being read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= '0;
    end else begin
      if (rd_last) begin
        full[rd_bank] <= 1'b0;
      end
      if (wr_last) begin
        full[wr_bank] <= 1'b1;
      end
    end
  end

  // Read FSM: IDLE waits for the next bank in order to be full, READ issues
  // one address per cycle, GAP forces a low cycle on fft_input_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state <= IDLE;
      rd_bank  <= 1'b0;
      rd_addr  <= '0;
    end else begin
      case (rd_state)
        IDLE: begin
          if (full[rd_bank]) begin
            rd_state <= READ;
            rd_addr  <= '0;
          end
        end
        READ: begin
          rd_addr <= rd_addr + 1'b1;
          if (rd_addr == LAST_ADDR) begin
            rd_state <= GAP;
            rd_bank  <= ~rd_bank;
          end
        end
        GAP: begin
          rd_state <= IDLE;
        end
        default: begin
          rd_state <= IDLE;
        end
      endcase
    end
  end

  // Sample RAM write port.
  // NOTE: the sample array is deliberately left out of reset; its contents are
  // only ever read after being overwritten, and a reset would prevent it from
  // mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      ram[{wr_bank, wr_addr}] <= audio_input_data;
    end
  end

  // Synchronous read port and output register; valid is the read enable
  // delayed by the one cycle the RAM read takes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fft_input       <= '0;
      fft_input_valid <= 1'b0;
    end else begin
      fft_input_valid <= rd_en;
      if (rd_en) begin
        fft_input <= ram[{rd_bank, rd_addr}];
      end
    end
  end

`ifdef FFT_INPUT_BUFFER_START_PULSE_EN
  // Start pulse travels with the sample read from address 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fft_input_start <= 1'b0;
    end else begin
      fft_input_start <= rd_en & (rd_addr == '0);
    end
  end
`endif

endmodule

// File: tb/tb_fft_window_input_buffer.sv
// Self-checking bench for fft_window_input_buffer.
// A table of stream scenarios is driven in a loop; the reference model is the
// plain rule "every output sample is the oldest accepted sample not yet
// emitted, bursts are exactly NS long, and a burst only carries completed
// windows". Hand-written sequences cover reset and a mid-window reset.
module tb_fft_window_input_buffer;

  localparam int W  = 16;
  localparam int NS = 1024;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] audio_input_data  = '0;
  logic         audio_input_valid = 1'b0;
  logic         audio_input_ready;
  logic [W-1:0] fft_input;
  logic         fft_input_valid;
`ifdef FFT_INPUT_BUFFER_START_PULSE_EN
  logic         fft_input_start;
`endif

  always #5 clk = ~clk;

  fft_window_input_buffer #(
    .W        (W),
    .NSamples (NS)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .audio_input_data  (audio_input_data),
    .audio_input_valid (audio_input_valid),
    .audio_input_ready (audio_input_ready),
    .fft_input         (fft_input),
    .fft_input_valid   (fft_input_valid)
`ifdef FFT_INPUT_BUFFER_START_PULSE_EN
    ,
    .fft_input_start   (fft_input_start)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / monitor (all sampling at negedge) ----
  logic [W-1:0] acc_q[$];      // accepted, not yet emitted samples
  int acc_cnt      = 0;        // samples accepted since last reset
  int out_cnt      = 0;        // samples emitted since last reset
  int bursts_done  = 0;        // finished bursts since last reset
  int total_bursts = 0;        // finished bursts over the whole run
  int run_len      = 0;
  int cyc          = 0;
  int last_done_cyc = 0;
  bit lat_en       = 1'b0;

  always @(negedge clk) begin
    int pending;
    logic [W-1:0] exp_s;
    cyc++;
    if (!reset) begin
      acc_q.delete();
      acc_cnt     = 0;
      out_cnt     = 0;
      bursts_done = 0;
      run_len     = 0;
    end else begin
      // Ready: two completed-but-unreplayed windows are needed to block the
      // writer; with at most one the producer must never be stalled.
      pending = acc_cnt / NS - bursts_done;
      if (pending <= 1) check("ready_high", audio_input_ready, 1'b1);
      if (!audio_input_ready) check("ready_low_cause", pending >= 2, 1'b1);

      if (fft_input_valid) begin
        if (run_len == 0 && lat_en)
          check("latency_le3", (cyc - last_done_cyc) <= 3, 1'b1);
        check("from_complete_window", out_cnt < (acc_cnt / NS) * NS, 1'b1);
        if (acc_q.size() > 0) begin
          exp_s = acc_q.pop_front();
          check("fft_data", fft_input, exp_s);
        end
`ifdef FFT_INPUT_BUFFER_START_PULSE_EN
        check("start_pulse", fft_input_start, run_len == 0);
`endif
        out_cnt++;
        run_len++;
      end else begin
        if (run_len != 0) begin
          check("burst_len", run_len, NS);
          bursts_done++;
          total_bursts++;
          run_len = 0;
        end
`ifdef FFT_INPUT_BUFFER_START_PULSE_EN
        check("start_idle", fft_input_start, 1'b0);
`endif
      end

      // Record this cycle's transfer (it happens on the coming posedge).
      if (audio_input_valid && audio_input_ready) begin
        acc_q.push_back(audio_input_data);
        acc_cnt++;
        // The accepting edge is the one after this sample point.
        if (acc_cnt % NS == 0) last_done_cyc = cyc + 1;
      end
    end
  end

  // ---------------- stimulus -----------------------------------------------
  typedef struct {
    string name;
    int    period;      // 0 = random valid, else valid every period-th cycle
    int    n;           // samples to send
    bit    ramp;        // ramp data from base, else random data
    int    base;
    bit    lat;         // check last-sample-to-first-valid latency
    int    max_cycles;  // allowed producer cycles (throughput bound)
    int    exp_bursts;
  } vec_t;

  vec_t vec[4];

  // Drive a stream, holding data/valid while not accepted.
  task automatic send_stream(input int period, input int n, input bit ramp, input int base,
                             input int budget, output int sent, output int used);
    int c = 0;
    bit hold = 1'b0;
    logic [W-1:0] cur;
    sent = 0;
    cur = ramp ? W'(base) : W'($urandom);
    while (sent < n && c < budget) begin
      @(posedge clk); #1;
      c++;
      if (!hold) begin
        audio_input_valid = (period == 0) ? ($urandom_range(0, 2) != 0) : ((c % period) == 0);
        audio_input_data  = cur;
      end
      @(negedge clk);
      if (audio_input_valid && audio_input_ready) begin
        sent++;
        hold = 1'b0;
        cur  = ramp ? W'(base + sent) : W'($urandom);
      end else begin
        hold = audio_input_valid;
      end
    end
    @(posedge clk); #1;
    audio_input_valid = 1'b0;
    used = c;
  endtask

  task automatic wait_bursts(input int b0, input int exp_b);
    int w = 0;
    while (total_bursts - b0 < exp_b && w < 4 * NS) begin
      @(negedge clk);
      w++;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2 reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_valid", fft_input_valid, 1'b0);
      check("rst_ready", audio_input_ready, 1'b1);
      check("rst_data", fft_input, '0);
    end
    @(posedge clk); #2 reset = 1'b1;
  endtask

  initial begin
    int sent, used, b0;

    vec[0] = '{"slow_ramp",  6, NS,     1'b1, 0,      1'b1, 6 * NS + 6,     1};
    vec[1] = '{"slow_3win",  6, 3 * NS, 1'b1, 0,      1'b1, 18 * NS + 6,    3};
    vec[2] = '{"full_rate",  1, 4 * NS, 1'b0, 0,      1'b0, 4 * NS + 32,    4};
    vec[3] = '{"rand_valid", 0, 2 * NS, 1'b0, 0,      1'b0, 6 * NS,         2};

    // Reset held for 5 cycles with the producer offering data.
    audio_input_valid = 1'b1;
    audio_input_data  = 16'hdead;
    repeat (5) begin
      @(negedge clk);
      check("rst_valid", fft_input_valid, 1'b0);
      check("rst_ready", audio_input_ready, 1'b1);
      check("rst_data", fft_input, '0);
    end
    audio_input_valid = 1'b0;
    @(posedge clk); #2 reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      b0     = total_bursts;
      lat_en = vec[i].lat;
      send_stream(vec[i].period, vec[i].n, vec[i].ramp, vec[i].base,
                  vec[i].max_cycles + 1, sent, used);
      check({vec[i].name, "_sent"}, sent, vec[i].n);
      check({vec[i].name, "_cycles"}, used <= vec[i].max_cycles, 1'b1);
      wait_bursts(b0, vec[i].exp_bursts);
      check({vec[i].name, "_bursts"}, total_bursts - b0, vec[i].exp_bursts);
      check({vec[i].name, "_leftover"}, acc_q.size(), 0);
      lat_en = 1'b0;
      apply_reset();
    end

    // Mid-window reset: a partial window must vanish without a burst.
    b0 = total_bursts;
    send_stream(1, 500, 1'b1, 16'h5000, 600, sent, used);
    check("partial_sent", sent, 500);
    repeat (20) @(negedge clk);
    check("partial_no_burst", total_bursts - b0, 0);
    apply_reset();
    b0 = total_bursts;
    lat_en = 1'b1;
    send_stream(2, NS, 1'b1, 16'h7000, 2 * NS + 4, sent, used);
    check("after_rst_sent", sent, NS);
    wait_bursts(b0, 1);
    check("after_rst_bursts", total_bursts - b0, 1);
    check("after_rst_leftover", acc_q.size(), 0);
    lat_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_window_input_buffer.md
# fft_window_input_buffer

Framing buffer between the audio sample stream and the FFT core (`fft_input_buffer`). It collects NSamples consecutive W-bit samples from a `dstream` valid/ready input into one of two ping-pong RAM banks. Each full window is replayed to the FFT as an uninterrupted burst of NSamples words, oldest first. The block uses one clock domain; the audio samples are already synchronised to `clk`.

## Interface
Parameters:
- `W`, 16, sample width in bits.
- `NSamples`, 1024, window length. Must be a power of two, ≥ 4.

Ports:
- `clk`  in  1  system clock; all logic is clocked on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock domain.
- `audio_input`  dstream interface, sink side, N=W:
  - `data` [W-1:0] in.
  - `valid` in.
  - `ready` out.
- `fft_input`  out  W  sample to the FFT.
- `fft_input_valid`  out  1  high while `fft_input` carries a window sample.
- `fft_input_start`  out  1  present only with `FFT_INPUT_BUFFER_START_PULSE_EN`.

`dstream` is an interface parameterised by N, with signals `data[N-1:0]`, `valid` and `ready`.

## Operation
- **Handshake:** a sample transfers on any rising edge where `valid && ready`.
- **Write side:**
  - Write pointer `wr_addr` is $clog2(NSamples) bits and is paired with write bank `wr_bank`.
  - Each accepted sample is written to RAM[wr_bank][wr_addr], then `wr_addr` increments.
  - On the write with `wr_addr == NSamples-1`:
    - `wr_addr` wraps to 0.
    - The bank is marked full.
    - `wr_bank` toggles.
- **Read FSM:**
  - IDLE:
    - Moves to READ when any bank is full and not being read.
    - Latches that bank as `rd_bank`.
    - Sets `rd_addr` = 0.
  - READ:
    - Issues one read per cycle, `rd_addr` 0..NSamples-1.
    - After issuing address NSamples-1, clears the bank's full flag and goes to GAP.
  - GAP: lasts one cycle, then returns to IDLE.
  - The GAP state guarantees `fft_input_valid` is low for at least one cycle between windows.
- **Ready:** `ready` is 1 unless `wr_bank` is still full, i.e. its previous window has not yet been fully read. While `ready` is 0 no samples are lost; the producer stalls.
- **Simultaneous events:** a write that completes bank B in the same cycle the reader finishes bank A is legal. Bank B becomes full and is started after GAP.
- **Sample order:** samples leave in exactly the order they were accepted. Window k+1 begins with the sample following the last sample of window k, with no gaps or duplicates.

## Timing
- **RAM:** synchronous-read.
  - `fft_input` is registered; `fft_input_valid` is a one-cycle-delayed copy of the READ-state read enable.
  - `fft_input_valid` is high for exactly NSamples consecutive cycles per window.
  - `fft_input` is the sample at index n on the n-th valid cycle.
- **Latency:** from the accepting edge of the last sample of a window to the first `fft_input_valid` is ≤ 3 clk cycles.
- **Throughput:** sustained input of one sample per cycle must not overflow. Stalls are permitted only when the reader lags because of GAP cycles.
- **Reset** (asynchronous assert, synchronous release effect on the first edge after deassert):
  - `fft_input_valid`=0, `fft_input`=0, `ready`=1, `fft_input_start`=0.
  - Pointers are 0, `wr_bank`=0, full flags are cleared, FSM is in IDLE.
  - RAM contents are not reset.
  - A reset mid-window discards any partial window or burst; output restarts cleanly.

## Configuration
- `FFT_INPUT_BUFFER_START_PULSE_EN` defined:
  - Adds output `fft_input_start`, a 1-cycle pulse coincident with the first `fft_input_valid` cycle of each window (sample index 0).
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset check:** hold `reset`=0 for 5 cycles -> `fft_input_valid`=0, `ready`=1, no writes occur.
- **Slow producer:** 1024 samples from a ramp 0x0000..0x03FF, `valid` every 6th cycle -> exactly one burst, `fft_input_valid` high for 1024 consecutive cycles, `fft_input` = 0x0000..0x03FF in order.
- **Continuous stream:** 3 windows with the same slow producer -> 3 bursts, each 1024 cycles, separated by ≥1 low cycle. Window 2 starts with the 1025th sample.
- **Full-rate input:** `valid`=1 every cycle for 4096 samples -> each burst's data matches the input order, none dropped or duplicated. `ready` drops only while the target bank is still full.
- **Mid-window reset:** assert reset after 500 samples, then stream 1024 new samples -> one burst containing only the new samples.
- **Start pulse:** with `FFT_INPUT_BUFFER_START_PULSE_EN` defined, `fft_input_start` pulses once per window, aligned with index 0.
